// File: rtl/min_sec_counter_if.sv
// Button levels in, minutes:seconds and status flags out, for min_sec_counter.
interface min_sec_counter_if;
  logic       btn_start;
  logic       btn_clear;
  logic       btn_inc_min;
  logic       dir;
  logic [5:0] cnt_min;
  logic [5:0] cnt_sec;
  logic       running;
  logic       rollover;
  logic       expired;

  modport master (
    output btn_start, btn_clear, btn_inc_min, dir,
    input  cnt_min, cnt_sec, running, rollover, expired
  );

  modport slave (
    input  btn_start, btn_clear, btn_inc_min, dir,
    output cnt_min, cnt_sec, running, rollover, expired
  );
endinterface

// File: rtl/min_sec_counter.sv
// Stopwatch/timer minutes:seconds counter with 1 Hz prescaler and button control.
// Define MIN_SEC_COUNTER_COUNTDOWN_EN to add down-counting with the expired pulse.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | counts held, prescaler held at 0
// S_RUN   | prescaler advances, each tick updates the count
// S_PAUSE | counts held, prescaler keeps its partial second
module min_sec_counter #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  min_sec_counter_if.slave  bus
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [5:0]    min_q, min_d;
  logic [5:0]    sec_q, sec_d;
  logic          running_q, running_d;
  logic          rollover_q, rollover_d;
  // Button bit order: {inc_min, clear, start}
  logic [2:0]    sync1_q, sync2_q, prev_q;
  logic [2:0]    btn_raw, btn_evt;
  logic          ev_start, ev_clear, ev_inc, tick, start_ok;

  assign btn_raw  = {bus.btn_inc_min, bus.btn_clear, bus.btn_start};
  assign btn_evt  = sync2_q & ~prev_q;
  assign ev_start = btn_evt[0];
  assign ev_clear = btn_evt[1];
  assign ev_inc   = btn_evt[2];
  assign tick     = (state_q == S_RUN) && (presc_q == PRESC_LAST);

`ifdef MIN_SEC_COUNTER_COUNTDOWN_EN
  logic down_q, down_d;
  logic expired_q, expired_d;

  // A down-count from 00:00 would underflow, so such a start is refused.
  assign start_ok    = !(bus.dir && (min_q == 6'd0) && (sec_q == 6'd0));
  assign bus.expired = expired_q;
`else
  logic unused_dir;

  assign unused_dir  = bus.dir;
  assign start_ok    = 1'b1;
  assign bus.expired = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    min_d      = min_q;
    sec_d      = sec_q;
    rollover_d = 1'b0;
`ifdef MIN_SEC_COUNTER_COUNTDOWN_EN
    down_d     = down_q;
    expired_d  = 1'b0;
`endif
    if (ev_clear) begin
      state_d = S_IDLE;
      presc_d = '0;
      min_d   = 6'd0;
      sec_d   = 6'd0;
    end else if (ev_start) begin
      // A start that lands on a tick edge swallows the tick.
      if (state_q == S_RUN) begin
        state_d = S_PAUSE;
      end else if (start_ok) begin
        state_d = S_RUN;
`ifdef MIN_SEC_COUNTER_COUNTDOWN_EN
        down_d  = bus.dir;
`endif
      end
    end else if (ev_inc && (state_q != S_RUN)) begin
      min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
    end else if (state_q == S_RUN) begin
      presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
      if (tick) begin
`ifdef MIN_SEC_COUNTER_COUNTDOWN_EN
        if (down_q) begin
          if (sec_q == 6'd0) begin
            sec_d = 6'd59;
            min_d = min_q - 6'd1;
          end else begin
            sec_d = sec_q - 6'd1;
          end
          if ((min_q == 6'd0) && (sec_q == 6'd1)) begin
            expired_d = 1'b1;
            state_d   = S_IDLE;
          end
        end else
`endif
        begin
          if (sec_q == 6'd59) begin
            sec_d = 6'd0;
            if (min_q == 6'd59) begin
              min_d      = 6'd0;
              rollover_d = 1'b1;
            end else begin
              min_d = min_q + 6'd1;
            end
          end else begin
            sec_d = sec_q + 6'd1;
          end
        end
      end
    end
    running_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      prev_q     <= '0;
      state_q    <= S_IDLE;
      presc_q    <= '0;
      min_q      <= 6'd0;
      sec_q      <= 6'd0;
      running_q  <= 1'b0;
      rollover_q <= 1'b0;
`ifdef MIN_SEC_COUNTER_COUNTDOWN_EN
      down_q     <= 1'b0;
      expired_q  <= 1'b0;
`endif
    end else begin
      sync1_q    <= btn_raw;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      state_q    <= state_d;
      presc_q    <= presc_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      running_q  <= running_d;
      rollover_q <= rollover_d;
`ifdef MIN_SEC_COUNTER_COUNTDOWN_EN
      down_q     <= down_d;
      expired_q  <= expired_d;
`endif
    end
  end

  assign bus.cnt_min  = min_q;
  assign bus.cnt_sec  = sec_q;
  assign bus.running  = running_q;
  assign bus.rollover = rollover_q;
endmodule

// File: tb/tb_min_sec_counter.sv
// Scoreboard bench for min_sec_counter: a total-seconds reference model queues the
// expected outputs for every clock edge and a negedge monitor compares them.
module tb_min_sec_counter;
  localparam int TD = 4;
`ifdef MIN_SEC_COUNTER_COUNTDOWN_EN
  localparam bit CD = 1'b1;
`else
  localparam bit CD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  min_sec_counter_if bus();
  min_sec_counter #(.TICK_DIV(TD)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    int mn;
    int sc;
    bit run;
    bit roll;
    bit expd;
  } snap_t;

  snap_t exp_q[$];
  snap_t e;
  int    n_checks = 0;
  int    n_fail   = 0;

  // Reference model: elapsed time as total seconds, mode 0 idle / 1 run / 2 pause.
  int       m_mode, m_t, m_phase;
  bit       m_down, m_roll, m_exp;
  bit [3:0] h_st, h_cl, h_inc;
  bit       e_st, e_cl, e_inc;

  function automatic snap_t cur_snap();
    snap_t s;
    s.mn   = m_t / 60;
    s.sc   = m_t % 60;
    s.run  = (m_mode == 1);
    s.roll = m_roll;
    s.expd = m_exp;
    return s;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_t = 0; m_phase = 0; m_down = 0; m_roll = 0; m_exp = 0;
    h_st = '0; h_cl = '0; h_inc = '0;
  endtask

  // A level first seen high two edges ago, and low the edge before, is one press.
  task automatic model_step();
    h_st  = {h_st[2:0],  bus.btn_start};
    h_cl  = {h_cl[2:0],  bus.btn_clear};
    h_inc = {h_inc[2:0], bus.btn_inc_min};
    e_st  = h_st[2]  & ~h_st[3];
    e_cl  = h_cl[2]  & ~h_cl[3];
    e_inc = h_inc[2] & ~h_inc[3];
    m_roll = 0;
    m_exp  = 0;
    if (e_cl) begin
      m_mode = 0; m_t = 0; m_phase = 0;
    end else if (e_st) begin
      if (m_mode == 1) m_mode = 2;
      else if (!(CD && bus.dir && m_t == 0)) begin
        m_mode = 1;
        m_down = CD && bus.dir;
      end
    end else if (e_inc && m_mode != 1) begin
      m_t = (((m_t / 60) + 1) % 60) * 60 + (m_t % 60);
    end else if (m_mode == 1) begin
      if (m_phase == TD - 1) begin
        m_phase = 0;
        if (m_down) begin
          m_t = m_t - 1;
          if (m_t == 0) begin
            m_exp  = 1;
            m_mode = 0;
          end
        end else begin
          m_t    = (m_t + 1) % 3600;
          m_roll = (m_t == 0);
        end
      end else begin
        m_phase = m_phase + 1;
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      model_reset();
      exp_q.delete();
    end else begin
      model_step();
    end
    exp_q.push_back(cur_snap());
  end

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("cnt_min",  int'(bus.cnt_min),  e.mn);
      check("cnt_sec",  int'(bus.cnt_sec),  e.sc);
      check("running",  int'(bus.running),  int'(e.run));
      check("rollover", int'(bus.rollover), int'(e.roll));
      check("expired",  int'(bus.expired),  int'(e.expd));
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic set_btn(input int which, input logic v);
    case (which)
      0:       bus.btn_start   = v;
      1:       bus.btn_clear   = v;
      default: bus.btn_inc_min = v;
    endcase
  endtask

  task automatic press(input int which, input int hold);
    set_btn(which, 1'b1);
    cyc(hold);
    set_btn(which, 1'b0);
    cyc(3);
  endtask

  task automatic wait_model_t(input int target, input int budget, input string name);
    for (int i = 0; i < budget && m_t != target; i++) cyc(1);
    if (m_t != target) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: wait expired, model time %0d, expected %0d", name, m_t, target);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.btn_start = 1'b0; bus.btn_clear = 1'b0; bus.btn_inc_min = 1'b0; bus.dir = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(2);

    // Start from reset, watch the first ticks.
    press(0, 1);
    cyc(12);

    // Preset 59:00 by presses, then run through 59:58, 59:59 and the wrap.
    press(1, 2);
    for (int i = 0; i < 59; i++) press(2, 1);
    press(0, 2);
    cyc(62 * TD);

    // Pause mid-second, hold, resume, then clear together with start.
    press(1, 1);
    press(0, 1);
    wait_model_t(3, 40, "reach_00_03");
    cyc(1);
    press(0, 1);
    cyc(20);
    press(0, 1);
    cyc(3 * TD);
    bus.btn_clear = 1'b1; bus.btn_start = 1'b1;
    cyc(2);
    bus.btn_clear = 1'b0; bus.btn_start = 1'b0;
    cyc(5);

    // 61 minute presses from idle, then a press while running.
    for (int i = 0; i < 61; i++) press(2, 1);
    press(0, 1);
    press(2, 1);
    cyc(2 * TD);
    press(0, 1);
    press(2, 1);
    cyc(3);

`ifdef MIN_SEC_COUNTER_COUNTDOWN_EN
    // Countdown: refused at 00:00, then 01:00 down to expiry.
    press(1, 1);
    bus.dir = 1'b1;
    press(0, 1);
    cyc(5);
    press(2, 1);
    press(0, 1);
    bus.dir = 1'b0;
    cyc(61 * TD + 10);
`endif

    // Asynchronous reset at 12:34, mid-second.
    press(1, 1);
    bus.dir = 1'b0;
    for (int i = 0; i < 12; i++) press(2, 1);
    press(0, 1);
    wait_model_t(12 * 60 + 34, 200 * TD, "reach_12_34");
    cyc(1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_min",      int'(bus.cnt_min),  0);
    check("async_rst_sec",      int'(bus.cnt_sec),  0);
    check("async_rst_running",  int'(bus.running),  0);
    check("async_rst_rollover", int'(bus.rollover), 0);
    check("async_rst_expired",  int'(bus.expired),  0);
    cyc(2);
    rst_n = 1'b1;
    cyc(2);

    // Random button levels and direction.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 30)  == 0) bus.btn_start   = ~bus.btn_start;
      if ($urandom_range(0, 300) == 0) bus.btn_clear   = ~bus.btn_clear;
      if ($urandom_range(0, 12)  == 0) bus.btn_inc_min = ~bus.btn_inc_min;
      if ($urandom_range(0, 50)  == 0) bus.dir         = ~bus.dir;
      cyc(1);
    end
    cyc(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
